// File: rtl/mem_pkg.sv
// Shared types for the execute-stage memory access unit.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int OP_ADDR_W  = 32;
    localparam int OP_DATA_W  = 32;

    // One latched single-word transaction.
    typedef struct packed {
        logic                 we;
        logic                 sp_upd;
        logic                 push;
        logic [OP_ADDR_W-1:0] addr;
        logic [OP_DATA_W-1:0] data;
    } mem_op_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit request-cycle counter; expired_o flags the last permitted REQ cycle.
module mem_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Execute-stage LD/ST/PUSH/POP responder owning the stack pointer.
// Optional stack overflow/underflow faults: define STACK_BOUNDS_CHECK_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] SP_RESET = 32'h0000_FFFC,
    parameter int                TIMEOUT  = 255,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 32'h0000_F000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memrd,
    input  logic              memwr,
    input  logic              MemInSel,
    input  logic              SPwe,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    mem_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              start, pop_op, start_err, stack_fault, expired;
    logic [ADDR_W-1:0] sp_dec, sel_addr;

    assign start  = memrd | memwr;
    assign pop_op = memrd & SPwe;
    assign sp_dec = sp_q - ADDR_W'(WORD_BYTES);

    always_comb begin
        sel_addr = alu_addr;
        if (MemInSel) begin
            sel_addr = sp_dec;
        end else if (pop_op) begin
            sel_addr = sp_q;
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    assign stack_fault = (MemInSel && (sp_dec < SP_LIMIT)) || (pop_op && (sp_q == SP_RESET));
`else
    logic unused_sp_limit;
    assign unused_sp_limit = ^SP_LIMIT;
    assign stack_fault     = 1'b0;
`endif

    assign start_err = (memrd & memwr) | (sel_addr[1:0] != 2'b00) | stack_fault;

    mem_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != REQ),
        .en_i     (state_q == REQ),
        .expired_o(expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        err_d     = err_q;
        sp_d      = sp_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d.we     = memwr;
                    op_d.sp_upd = SPwe;
                    op_d.push   = MemInSel;
                    op_d.addr   = sel_addr;
                    op_d.data   = wr_data;
                    err_d       = start_err;
                    state_d     = start_err ? DONE : REQ;
                end
            end
            REQ: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    if (!op_q.we) begin
                        rd_data_d = mem_rdata;
                    end
                    if (op_q.sp_upd) begin
                        sp_d = op_q.push ? sp_dec : sp_q + ADDR_W'(WORD_BYTES);
                    end
                    state_d = DONE;
                end else if (expired) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            err_q     <= 1'b0;
            sp_q      <= SP_RESET;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            err_q     <= err_d;
            sp_q      <= sp_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign stall     = ((state_q == IDLE) && start) || (state_q == REQ);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && op_q.we;
    assign mem_addr  = op_q.addr;
    assign mem_wdata = op_q.data;
    assign rd_valid  = (state_q == DONE) && !err_q && !op_q.we;
    assign bus_err   = (state_q == DONE) && err_q;
    assign rd_data   = rd_data_q;
    assign sp        = sp_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (built with TIMEOUT=4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        memrd, memwr, MemInSel, SPwe, mem_ack;
    logic [31:0] alu_addr, wr_data, mem_rdata;
    logic [31:0] rd_data, sp, mem_addr, mem_wdata;
    logic        rd_valid, stall, mem_req, mem_we, bus_err;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .SP_RESET(32'h0000_FFFC),
        .TIMEOUT (4),
        .SP_LIMIT(32'h0000_F000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .memrd    (memrd),
        .memwr    (memwr),
        .MemInSel (MemInSel),
        .SPwe     (SPwe),
        .alu_addr (alu_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .stall    (stall),
        .sp       (sp),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        memrd = 0; memwr = 0; MemInSel = 0; SPwe = 0; mem_ack = 0;
        alu_addr = '0; wr_data = '0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst_n = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (sp !== 32'h0000_FFFC) begin errors++; $display("FAIL rst_sp got=%h exp=0000fffc", sp); end
        tick();
        checks++; if ({stall, rd_valid, bus_err, mem_we} !== 4'b0) begin errors++; $display("FAIL rst_ctl got=%b exp=0000", {stall, rd_valid, bus_err, mem_we}); end
        checks++; if ({rd_data, mem_addr, mem_wdata} !== 96'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {rd_data, mem_addr, mem_wdata}); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_store();
        int stall_cnt = 0;
        memwr = 1; alu_addr = 32'h100; wr_data = 32'hDEAD_BEEF;
        #1;
        stall_cnt += int'(stall);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL st_idle_req got=%b exp=0", mem_req); end
        tick();
        stall_cnt += int'(stall);
        checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL st_req1 got=%b exp=11", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_bus got=%h/%h exp=100/deadbeef", mem_addr, mem_wdata); end
        tick();
        stall_cnt += int'(stall);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL st_req2 got=%b/%h exp=1/100", mem_req, mem_addr); end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        stall_cnt += int'(stall);
        checks++; if ({mem_req, rd_valid, bus_err} !== 3'b000) begin errors++; $display("FAIL st_done got=%b exp=000", {mem_req, rd_valid, bus_err}); end
        checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL st_stall_cycles got=%0d exp=3", stall_cnt); end
        checks++; if (sp !== 32'h0000_FFFC) begin errors++; $display("FAIL st_sp got=%h exp=0000fffc", sp); end
        clear_inputs();
        tick();
    endtask

    task automatic test_push_pop();
        memwr = 1; MemInSel = 1; SPwe = 1; wr_data = 32'h1234; alu_addr = 32'h555;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL push_stall got=%b exp=1", stall); end
        tick();
        checks++; if (mem_addr !== 32'hFFF8 || mem_we !== 1'b1 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL push_bus got=%h/%b/%h exp=fff8/1/1234", mem_addr, mem_we, mem_wdata); end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        checks++; if (sp !== 32'hFFF8 || bus_err !== 1'b0) begin errors++; $display("FAIL push_sp got=%h/%b exp=fff8/0", sp, bus_err); end
        clear_inputs();
        tick();
        memrd = 1; SPwe = 1; alu_addr = 32'h777;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFF8 || mem_we !== 1'b0) begin errors++; $display("FAIL pop_bus got=%b/%h/%b exp=1/fff8/0", mem_req, mem_addr, mem_we); end
        mem_ack = 1; mem_rdata = 32'h1234;
        tick();
        mem_ack = 0; mem_rdata = 32'hFFFF_FFFF;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234) begin errors++; $display("FAIL pop_data got=%b/%h exp=1/1234", rd_valid, rd_data); end
        checks++; if (sp !== 32'hFFFC) begin errors++; $display("FAIL pop_sp got=%h exp=fffc", sp); end
        clear_inputs();
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL pop_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_misaligned();
        memrd = 1; alu_addr = 32'h102;
        #1;
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_idle got=%b/%b exp=1/0", stall, mem_req); end
        tick();
        checks++; if ({mem_req, bus_err, rd_valid, stall} !== 4'b0100) begin errors++; $display("FAIL mis_done got=%b exp=0100", {mem_req, bus_err, rd_valid, stall}); end
        checks++; if (rd_data !== 32'h1234) begin errors++; $display("FAIL mis_hold got=%h exp=1234", rd_data); end
        clear_inputs();
        tick();
        checks++; if (bus_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_after got=%b/%b exp=0/0", bus_err, mem_req); end
    endtask

    task automatic test_both_err();
        memrd = 1; memwr = 1; alu_addr = 32'h200;
        tick();
        checks++; if ({mem_req, bus_err, rd_valid} !== 3'b010) begin errors++; $display("FAIL both_done got=%b exp=010", {mem_req, bus_err, rd_valid}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        memrd = 1; alu_addr = 32'h300;
        tick();
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
        checks++; if ({bus_err, rd_valid, stall} !== 3'b100) begin errors++; $display("FAIL to_done got=%b exp=100", {bus_err, rd_valid, stall}); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL to_rdata got=%h exp=0", rd_data); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        memwr = 1; MemInSel = 1; SPwe = 1; wr_data = 32'hAAAA;
        tick();
        mem_ack = 1;
        tick();
        mem_ack = 0;
        checks++; if (sp !== 32'hFFF8) begin errors++; $display("FAIL rm_push_sp got=%h exp=fff8", sp); end
        clear_inputs();
        tick();
        memwr = 1; MemInSel = 1; SPwe = 1; wr_data = 32'hBBBB;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_req got=%b exp=1", mem_req); end
        #2;
        rst_n = 0;
        clear_inputs();
        #1;
        checks++; if ({mem_req, stall, mem_we} !== 3'b000) begin errors++; $display("FAIL rm_async got=%b exp=000", {mem_req, stall, mem_we}); end
        checks++; if (sp !== 32'hFFFC || mem_addr !== 32'h0) begin errors++; $display("FAIL rm_sp got=%h/%h exp=fffc/0", sp, mem_addr); end
        tick();
        rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hCAFE;
        tick();
        mem_ack = 0;
        checks++; if ({mem_req, rd_valid, stall, bus_err} !== 4'b0000) begin errors++; $display("FAIL rm_late_ack got=%b exp=0000", {mem_req, rd_valid, stall, bus_err}); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || sp !== 32'hFFFC) begin errors++; $display("FAIL rm_after got=%b/%h/%h exp=0/0/fffc", rd_valid, rd_data, sp); end
    endtask

    task automatic test_load();
        memrd = 1; alu_addr = 32'h40;
        tick();
        checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL ld_bus got=%h/%b exp=40/0", mem_addr, mem_we); end
        mem_ack = 1; mem_rdata = 32'h5A5A_0001;
        tick();
        mem_ack = 0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h5A5A_0001 || sp !== 32'hFFFC) begin errors++; $display("FAIL ld_done got=%b/%h/%h exp=1/5a5a0001/fffc", rd_valid, rd_data, sp); end
        clear_inputs();
        tick();
    endtask

`ifdef STACK_BOUNDS_CHECK_EN
    task automatic test_bounds();
        memrd = 1; SPwe = 1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bc_pop_idle got=%b exp=0", mem_req); end
        tick();
        checks++; if ({mem_req, bus_err, rd_valid} !== 3'b010 || sp !== 32'hFFFC) begin errors++; $display("FAIL bc_underflow got=%b/%h exp=010/fffc", {mem_req, bus_err, rd_valid}, sp); end
        clear_inputs();
        tick();
        for (int i = 0; i < 1023; i++) begin
            memwr = 1; MemInSel = 1; SPwe = 1; wr_data = i;
            tick();
            mem_ack = 1;
            tick();
            clear_inputs();
            tick();
        end
        checks++; if (sp !== 32'hF000) begin errors++; $display("FAIL bc_fill_sp got=%h exp=f000", sp); end
        memwr = 1; MemInSel = 1; SPwe = 1; wr_data = 32'h9;
        tick();
        checks++; if ({mem_req, bus_err} !== 2'b01 || sp !== 32'hF000) begin errors++; $display("FAIL bc_overflow got=%b/%h exp=01/f000", {mem_req, bus_err}, sp); end
        clear_inputs();
        tick();
    endtask
`else
    task automatic test_pop_wrap();
        memrd = 1; SPwe = 1;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFC) begin errors++; $display("FAIL wrap_bus got=%b/%h exp=1/fffc", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h77;
        tick();
        mem_ack = 0;
        checks++; if (sp !== 32'h0001_0000 || bus_err !== 1'b0 || rd_data !== 32'h77) begin errors++; $display("FAIL wrap_sp got=%h/%b/%h exp=00010000/0/77", sp, bus_err, rd_data); end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_push_pop();
        test_misaligned();
        test_both_err();
        test_timeout();
        test_reset_mid();
        test_load();
`ifdef STACK_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_pop_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
